decode_queue: RTL and testbench

Buffered, pipelined successor to the single-cycle instruction decoder: a parametrised FIFO of fetched {pc, instr} pairs feeds a registered RV32I decode stage with valid/ready handshakes on both sides, flush, and illegal-instruction detection. It sits between fetch and the register-read/execute stage. It decouples fetch stalls from execute stalls at one instruction per cycle throughput.

---
 rtl/decode_queue.sv | 246 ++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: FIFO of fetched {pc, instr} pairs feeding a registered RV32I
// decode stage. Both sides use valid/ready handshakes, and flush discards all
// queued and registered instructions.
// Optional feature: define DECODE_MEXT_EN to accept RV32M (R-type funct7 = 0000001).
// alu_control encoding: R-type -> {funct7[5], funct3}; memory/upper/jalr -> 4'b0000 (add);
// branch -> 4'b1000 (sub); unset -> 4'b1111; illegal -> 4'b0000.
module decode_queue #(
    parameter int FIFO_DEPTH = 4,
    parameter int PC_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [PC_WIDTH-1:0]           in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [PC_WIDTH-1:0]           out_pc,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic [6:0]                    funct7,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [31:0]                   imm_ext,
    output logic [3:0]                    alu_control,
    output logic                          writes_rd,
    output logic                          uses_rs1,
    output logic                          uses_rs2,
    output logic                          illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_ILOGIC = 7'b0010011,
        OP_ILOAD  = 7'b0000011,
        OP_IJALR  = 7'b1100111,
        OP_S      = 7'b0100011,
        OP_B      = 7'b1100011,
        OP_J      = 7'b1101111,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [1:0] {
        UNSET,
        MEMORY_ACCESS,
        BRANCH,
        REGISTER_OPERATION
    } alu_op_e;

    logic [31:0]         mem_instr [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] mem_pc    [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                push, load;
    logic [31:0]         head_instr;
    logic [PC_WIDTH-1:0] head_pc;

    assign in_ready   = (count < CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    // Load decisions use the pre-edge count, so a fresh push is never bypassed.
    assign load       = (count != '0) && (!out_valid || out_ready);
    assign head_instr = mem_instr[rd_ptr];
    assign head_pc    = mem_pc[rd_ptr];

    // Queue storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    // Pointers and occupancy; flush empties the queue and drops same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic        legal, r_funct7_ok;
    logic        d_writes_rd, d_uses_rs1, d_uses_rs2, d_has_funct7;
    logic [31:0] d_imm;
    alu_op_e     d_alu_op;
    logic [3:0]  d_alu_control;

`ifdef DECODE_MEXT_EN
    assign r_funct7_ok = (head_instr[31:25] == 7'b0000000) || (head_instr[31:25] == 7'b0100000) ||
                         (head_instr[31:25] == 7'b0000001);
`else
    assign r_funct7_ok = (head_instr[31:25] == 7'b0000000) || (head_instr[31:25] == 7'b0100000);
`endif

    // Opcode classification of the FIFO head: operand usage, immediate and ALU op class.
    always_comb begin
        legal        = 1'b0;
        d_writes_rd  = 1'b0;
        d_uses_rs1   = 1'b0;
        d_uses_rs2   = 1'b0;
        d_has_funct7 = 1'b0;
        d_imm        = '0;
        d_alu_op     = UNSET;
        case (head_instr[6:0])
            OP_R: begin
                legal        = r_funct7_ok;
                d_writes_rd  = r_funct7_ok;
                d_uses_rs1   = r_funct7_ok;
                d_uses_rs2   = r_funct7_ok;
                d_has_funct7 = r_funct7_ok;
                d_alu_op     = REGISTER_OPERATION;
            end
            OP_ILOGIC: begin
                legal        = 1'b1;
                d_writes_rd  = 1'b1;
                d_uses_rs1   = 1'b1;
                d_has_funct7 = 1'b1;
                d_imm        = {{20{head_instr[31]}}, head_instr[31:20]};
            end
            OP_ILOAD, OP_IJALR: begin
                legal       = 1'b1;
                d_writes_rd = 1'b1;
                d_uses_rs1  = 1'b1;
                d_imm       = {{20{head_instr[31]}}, head_instr[31:20]};
                d_alu_op    = MEMORY_ACCESS;
            end
            OP_S: begin
                legal      = 1'b1;
                d_uses_rs1 = 1'b1;
                d_uses_rs2 = 1'b1;
                d_imm      = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
                d_alu_op   = MEMORY_ACCESS;
            end
            OP_B: begin
                legal      = 1'b1;
                d_uses_rs1 = 1'b1;
                d_uses_rs2 = 1'b1;
                d_imm      = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                              head_instr[30:25], head_instr[11:8], 1'b0};
                d_alu_op   = BRANCH;
            end
            OP_J: begin
                legal       = 1'b1;
                d_writes_rd = 1'b1;
                d_imm       = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                               head_instr[20], head_instr[30:21], 1'b0};
            end
            OP_AUIPC, OP_LUI: begin
                legal       = 1'b1;
                d_writes_rd = 1'b1;
                d_imm       = {head_instr[31:12], 12'b0};
                d_alu_op    = MEMORY_ACCESS;
            end
            default: legal = 1'b0;
        endcase
    end

    // ALU decoder: maps the op class plus function fields to an ALU control code.
    always_comb begin
        d_alu_control = 4'b0000;
        if (legal) begin
            case (d_alu_op)
                REGISTER_OPERATION: d_alu_control = {head_instr[30], head_instr[14:12]};
                MEMORY_ACCESS:      d_alu_control = 4'b0000;
                BRANCH:             d_alu_control = 4'b1000;
                default:            d_alu_control = 4'b1111;
            endcase
        end
    end

    // Output register: loads the decoded head, holds while stalled, clears on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            opcode      <= '0;
            funct3      <= '0;
            funct7      <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            imm_ext     <= '0;
            alu_control <= '0;
            writes_rd   <= 1'b0;
            uses_rs1    <= 1'b0;
            uses_rs2    <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            opcode      <= '0;
            funct3      <= '0;
            funct7      <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            imm_ext     <= '0;
            alu_control <= '0;
            writes_rd   <= 1'b0;
            uses_rs1    <= 1'b0;
            uses_rs2    <= 1'b0;
            illegal     <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_instr   <= head_instr;
            out_pc      <= head_pc;
            opcode      <= legal ? head_instr[6:0] : 7'b0;
            funct3      <= d_uses_rs1 ? head_instr[14:12] : 3'b0;
            funct7      <= d_has_funct7 ? head_instr[31:25] : 7'b0;
            rd          <= d_writes_rd ? head_instr[11:7] : 5'b0;
            rs1         <= d_uses_rs1 ? head_instr[19:15] : 5'b0;
            rs2         <= d_uses_rs2 ? head_instr[24:20] : 5'b0;
            imm_ext     <= d_imm;
            alu_control <= d_alu_control;
            writes_rd   <= d_writes_rd;
            uses_rs1    <= d_uses_rs1;
            uses_rs2    <= d_uses_rs2;
            illegal     <= !legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: reset, table-driven decode vectors,
// hand-written multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, imm_ext;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_control;
    logic        writes_rd, uses_rs1, uses_rs2, illegal;
    logic [2:0]  fifo_count;

    decode_queue #(.FIFO_DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm_ext(imm_ext), .alu_control(alu_control), .writes_rd(writes_rd),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .illegal(illegal), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        wr;
        logic        u1;
        logic        u2;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    dec_t dut_dec;
    assign dut_dec = '{op: opcode, f3: funct3, f7: funct7, rd: rd, rs1: rs1, rs2: rs2,
                       imm: imm_ext, alu: alu_control, wr: writes_rd, u1: uses_rs1,
                       u2: uses_rs2, ill: illegal};

    int tests = 0;
    int fails = 0;

    entry_t mq[$];
    logic   m_ov;
    entry_t m_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic dec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] imm, input logic [3:0] alu,
                                input logic wr, input logic u1, input logic u2, input logic ill);
        dec_t d;
        d = '{op: op, f3: f3, f7: f7, rd: rdv, rs1: r1, rs2: r2, imm: imm, alu: alu,
              wr: wr, u1: u1, u2: u2, ill: ill};
        return d;
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t       d;
        logic [6:0] op;
        logic [6:0] f7;
        logic       ok;
        d  = '0;
        op = i[6:0];
        f7 = i[31:25];
        ok = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37};
        if (op == 7'h33) begin
`ifdef DECODE_MEXT_EN
            ok = f7 inside {7'h00, 7'h20, 7'h01};
`else
            ok = f7 inside {7'h00, 7'h20};
`endif
        end
        if (!ok) begin
            d.ill = 1'b1;
            return d;
        end
        d.op  = op;
        d.wr  = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h17, 7'h37, 7'h6F};
        d.u1  = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
        d.u2  = op inside {7'h33, 7'h23, 7'h63};
        d.rd  = d.wr ? i[11:7] : 5'd0;
        d.rs1 = d.u1 ? i[19:15] : 5'd0;
        d.rs2 = d.u2 ? i[24:20] : 5'd0;
        d.f3  = d.u1 ? i[14:12] : 3'd0;
        d.f7  = (op == 7'h33 || op == 7'h13) ? f7 : 7'd0;
        case (op)
            7'h13, 7'h03, 7'h67: d.imm = $signed(i[31:20]);
            7'h23: d.imm = $signed({i[31:25], i[11:7]});
            7'h63: d.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            7'h6F: d.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            7'h17, 7'h37: d.imm = {i[31:12], 12'h000};
            default: d.imm = 32'd0;
        endcase
        case (op)
            7'h33:                       d.alu = {i[30], i[14:12]};
            7'h03, 7'h67, 7'h23, 7'h17, 7'h37: d.alu = 4'b0000;
            7'h63:                       d.alu = 4'b1000;
            default:                     d.alu = 4'b1111;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_out = '{pc: 32'd0, instr: 32'd0};
    endtask

    task automatic model_step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                              input logic ordy, input logic fl);
        int   sz;
        logic take, give;
        sz   = mq.size();
        take = iv && (sz < DEPTH);
        give = (sz > 0) && (!m_ov || ordy);
        if (fl) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            if (give) begin
                m_out = mq.pop_front();
                m_ov  = 1'b1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (take) mq.push_back('{pc: pc, instr: ins});
        end
    endtask

    task automatic check_state();
        check("out_valid", out_valid, m_ov);
        check("fifo_count", fifo_count, mq.size());
        check("in_ready", in_ready, mq.size() < DEPTH);
        if (m_ov) begin
            check("out_pc", out_pc, m_out.pc);
            check("out_instr", out_instr, m_out.instr);
            check("decode", dut_dec, ref_decode(m_out.instr));
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        model_step(iv, ins, pc, ordy, fl);
        check_state();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_valid"}, out_valid, 1'b0);
        check({tag, " fifo_count"}, fifo_count, 3'd0);
        check({tag, " in_ready"}, in_ready, 1'b1);
        check({tag, " fields"}, dut_dec, dec_t'(0));
        check({tag, " out_pc"}, out_pc, 32'd0);
        check({tag, " out_instr"}, out_instr, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37};
        i = $urandom;
        if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 8)];
        if (i[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: i[31:25] = 7'h00;
                1: i[31:25] = 7'h20;
                2: i[31:25] = 7'h01;
                default: ;
            endcase
        end
        return i;
    endfunction

    vec_t        vecs[$];
    logic [31:0] seen[$];
    logic [31:0] pcv;
    int          accepted;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        vecs.push_back('{"addi", 32'h00500093, mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 4'hF, 1, 1, 0, 0)});
        vecs.push_back('{"sw", 32'h00112223, mk(7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd1, 32'd4, 4'h0, 0, 1, 1, 0)});
        vecs.push_back('{"beq", 32'hFE000EE3, mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'h8, 0, 1, 1, 0)});
        vecs.push_back('{"lui", 32'h123452B7, mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 4'h0, 1, 0, 0, 0)});
        vecs.push_back('{"auipc", 32'hFFFFF117, mk(7'h17, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFFF000, 4'h0, 1, 0, 0, 0)});
        vecs.push_back('{"jal", 32'h008000EF, mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 4'hF, 1, 0, 0, 0)});
        vecs.push_back('{"jalr", 32'h000080E7, mk(7'h67, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0, 4'h0, 1, 1, 0, 0)});
        vecs.push_back('{"lw", 32'hFFC12183, mk(7'h03, 3'd2, 7'h00, 5'd3, 5'd2, 5'd0, 32'hFFFFFFFC, 4'h0, 1, 1, 0, 0)});
        vecs.push_back('{"add", 32'h002081B3, mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 4'h0, 1, 1, 1, 0)});
        vecs.push_back('{"sub", 32'h402081B3, mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 4'h8, 1, 1, 1, 0)});
        vecs.push_back('{"and", 32'h0020F1B3, mk(7'h33, 3'd7, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 4'h7, 1, 1, 1, 0)});
        vecs.push_back('{"srai", 32'h4030D093, mk(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'h403, 4'hF, 1, 1, 0, 0)});
        vecs.push_back('{"bad_op", 32'h0000007F, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 4'h0, 0, 0, 0, 1)});
        vecs.push_back('{"bad_f7", 32'h10208033, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 4'h0, 0, 0, 0, 1)});
`ifdef DECODE_MEXT_EN
        vecs.push_back('{"mul", 32'h02208033, mk(7'h33, 3'd0, 7'h01, 5'd0, 5'd1, 5'd2, 32'd0, 4'h0, 1, 1, 1, 0)});
`else
        vecs.push_back('{"mul", 32'h02208033, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 4'h0, 0, 0, 0, 1)});
`endif

        // Single-instruction latency and decode per vector.
        foreach (vecs[k]) begin
            cycle(1'b1, vecs[k].instr, 32'h1000 + 32'(k * 4), 1'b1, 1'b0);
            check({"no_bypass ", vecs[k].name}, out_valid, 1'b0);
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            check({"valid ", vecs[k].name}, out_valid, 1'b1);
            check({"vec ", vecs[k].name}, dut_dec, vecs[k].exp);
            check({"pc ", vecs[k].name}, out_pc, 32'h1000 + 32'(k * 4));
        end

        // Back-to-back sw then beq: consecutive out_valid cycles.
        cycle(1'b1, 32'h00112223, 32'h2000, 1'b1, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 32'h2004, 1'b1, 1'b0);
        check("b2b sw", dut_dec, vecs[1].exp);
        check("b2b sw valid", out_valid, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("b2b beq", dut_dec, vecs[2].exp);
        check("b2b beq valid", out_valid, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Fill with out_ready low: FIFO_DEPTH+1 accepted.
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            if (in_ready) accepted++;
            cycle(1'b1, 32'h00000013 | (32'(k) << 7), 32'h100 + 32'(k * 4), 1'b0, 1'b0);
        end
        check("full accepted", accepted, 5);
        check("full count", fifo_count, 3'd4);
        check("full in_ready", in_ready, 1'b0);
        seen.delete();
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen.push_back(out_pc);
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        check("drain len", seen.size(), 5);
        foreach (seen[k]) check($sformatf("drain pc%0d", k), seen[k], 32'h100 + 32'(k * 4));

        // Flush with valid output plus three queued, concurrent push dropped.
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h00100093, 32'h200 + 32'(k * 4), 1'b0, 1'b0);
        check("pre-flush count", fifo_count, 3'd3);
        check("pre-flush valid", out_valid, 1'b1);
        cycle(1'b1, 32'h00F00093, 32'h2F0, 1'b0, 1'b1);
        check("flush valid", out_valid, 1'b0);
        check("flush count", fifo_count, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            check("post-flush silent", out_valid, 1'b0);
        end

        // Asynchronous reset mid-transfer.
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h00200113, 32'h300 + 32'(k * 4), 1'b0, 1'b0);
        check("pre-reset valid", out_valid, 1'b1);
        check("pre-reset count", fifo_count, 3'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);
        check("post-reset count", fifo_count, 3'd0);

        // Randomized traffic against the reference model.
        pcv = 32'h8000;
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), pcv,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            pcv += 4;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
